// File: rtl/iop_buzzer_pwm.sv
// IOP-bus buzzer PWM peripheral.
// Registers (word offsets decoded on IOADDR[11:2]):
//   0x10 CYCLE  (RW) period length in clocks
//   0x14 DUTY   (RW) active clocks per period
//   0x18 CTRL   (RW) bit0 EN, bit1 POL (1 = active-low output)
//   0x1C STATUS (RO) bit0 RUN, bit1 PEND, bits[31:16] completed period count
// CYCLE/DUTY are copied into shadow registers only at a period boundary, so software
// updates never produce a truncated or glitched period.
// Ports:
//   HCLK, HRESET                  clock, synchronous active-high reset
//   IOSEL/IOTRANS/IOWRITE/IOSIZE  data-phase transfer qualifiers from the bridge
//   IOADDR, IOWDATA, IORDATA      address, write data, combinational read data
//   BUZZER                        registered PWM drive
//   PERIOD_DONE                   one-cycle pulse after each completed period
module iop_buzzer_pwm #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        IOSEL,
  input  logic [11:0] IOADDR,
  input  logic        IOWRITE,
  input  logic [1:0]  IOSIZE,
  input  logic        IOTRANS,
  input  logic [31:0] IOWDATA,
  output logic [31:0] IORDATA,
  output logic        BUZZER,
  output logic        PERIOD_DONE
);

  localparam logic [9:0] AddrCycle  = 10'h004;
  localparam logic [9:0] AddrDuty   = 10'h005;
  localparam logic [9:0] AddrCtrl   = 10'h006;
  localparam logic [9:0] AddrStatus = 10'h007;

  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic                 pol_q, pol_d;
  logic [CNT_WIDTH-1:0] cyc_sh_q, cyc_sh_d;
  logic [CNT_WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]          pcount_q, pcount_d;
  logic                 pend_q, pend_d;
  logic                 buzzer_q, buzzer_d;
  logic                 period_done_q, period_done_d;

  logic       acc;
  logic       wr_en;
  logic [9:0] word_addr;
  logic       wr_cycle, wr_duty, wr_ctrl;
  logic       run;
  logic       reload;
  logic       active;
  logic       unused_addr;

  assign acc         = IOSEL & IOTRANS;
  assign wr_en       = acc & IOWRITE & (IOSIZE == 2'b10);
  assign word_addr   = IOADDR[11:2];
  assign wr_cycle    = wr_en && (word_addr == AddrCycle);
  assign wr_duty     = wr_en && (word_addr == AddrDuty);
  assign wr_ctrl     = wr_en && (word_addr == AddrCtrl);
  assign run         = (state_q == StRun);
  assign unused_addr = ^IOADDR[1:0];

  always_comb begin
    state_d       = state_q;
    cycle_d       = cycle_q;
    duty_d        = duty_q;
    pol_d         = pol_q;
    cyc_sh_d      = cyc_sh_q;
    duty_sh_d     = duty_sh_q;
    cnt_d         = cnt_q;
    pcount_d      = pcount_q;
    pend_d        = pend_q;
    period_done_d = 1'b0;
    reload        = 1'b0;

    if (wr_cycle) cycle_d = IOWDATA[CNT_WIDTH-1:0];
    if (wr_duty)  duty_d  = IOWDATA[CNT_WIDTH-1:0];
    if (wr_ctrl)  pol_d   = IOWDATA[1];

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (wr_ctrl && IOWDATA[0]) begin
          // Enable: start a fresh period from the current register values.
          state_d   = StRun;
          cyc_sh_d  = cycle_q;
          duty_sh_d = duty_q;
          pend_d    = 1'b0;
          pcount_d  = '0;
        end
      end
      StRun: begin
        if (cyc_sh_q == '0) begin
          // Stalled counter: every cycle acts as a boundary for reload purposes.
          cnt_d  = '0;
          reload = pend_q;
        end else if (cnt_q == cyc_sh_q - CntOne) begin
          cnt_d         = '0;
          period_done_d = 1'b1;
          pcount_d      = pcount_q + 16'd1;
          reload        = pend_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end

        if (wr_ctrl && !IOWDATA[0]) begin
          // Disable wins over a coincident boundary; the completed period still pulses.
          state_d = StIdle;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          // Reload samples the registers before this cycle's write lands.
          if (reload) begin
            cyc_sh_d  = cycle_q;
            duty_sh_d = duty_q;
            pend_d    = 1'b0;
          end
          if (wr_cycle || wr_duty) pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    active   = (state_d == StRun) && (cyc_sh_d != '0) && (cnt_d < duty_sh_d);
    buzzer_d = active ^ pol_d;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= StIdle;
      cycle_q       <= '0;
      duty_q        <= '0;
      pol_q         <= 1'b0;
      cyc_sh_q      <= '0;
      duty_sh_q     <= '0;
      cnt_q         <= '0;
      pcount_q      <= '0;
      pend_q        <= 1'b0;
      buzzer_q      <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      duty_q        <= duty_d;
      pol_q         <= pol_d;
      cyc_sh_q      <= cyc_sh_d;
      duty_sh_q     <= duty_sh_d;
      cnt_q         <= cnt_d;
      pcount_q      <= pcount_d;
      pend_q        <= pend_d;
      buzzer_q      <= buzzer_d;
      period_done_q <= period_done_d;
    end
  end

  always_comb begin
    IORDATA = '0;
    if (acc && !IOWRITE) begin
      case (word_addr)
        AddrCycle:  IORDATA[CNT_WIDTH-1:0] = cycle_q;
        AddrDuty:   IORDATA[CNT_WIDTH-1:0] = duty_q;
        AddrCtrl:   IORDATA[1:0] = {pol_q, run};
        AddrStatus: begin
          IORDATA[31:16] = pcount_q;
          IORDATA[1]     = pend_q;
          IORDATA[0]     = run;
        end
        default: IORDATA = '0;
      endcase
    end
  end

  assign BUZZER      = buzzer_q;
  assign PERIOD_DONE = period_done_q;

endmodule

// File: tb/tb_iop_buzzer_pwm.sv
module tb_iop_buzzer_pwm;

  localparam logic [11:0] ACycle  = 12'h010;
  localparam logic [11:0] ADuty   = 12'h014;
  localparam logic [11:0] ACtrl   = 12'h018;
  localparam logic [11:0] AStatus = 12'h01C;
  localparam logic [11:0] AUnmap  = 12'h020;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        IOSEL = 1'b0;
  logic [11:0] IOADDR = '0;
  logic        IOWRITE = 1'b0;
  logic [1:0]  IOSIZE = 2'b10;
  logic        IOTRANS = 1'b0;
  logic [31:0] IOWDATA = '0;
  logic [31:0] IORDATA;
  logic        BUZZER;
  logic        PERIOD_DONE;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  iop_buzzer_pwm #(.CNT_WIDTH(32)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .IOSEL       (IOSEL),
    .IOADDR      (IOADDR),
    .IOWRITE     (IOWRITE),
    .IOSIZE      (IOSIZE),
    .IOTRANS     (IOTRANS),
    .IOWDATA     (IOWDATA),
    .IORDATA     (IORDATA),
    .BUZZER      (BUZZER),
    .PERIOD_DONE (PERIOD_DONE)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // One data-phase write; returns 1 ns after the edge that commits it.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge HCLK);
    IOSEL   = 1'b1;
    IOTRANS = 1'b1;
    IOWRITE = 1'b1;
    IOADDR  = a;
    IOWDATA = d;
    IOSIZE  = sz;
    @(posedge HCLK);
    #1;
    IOSEL   = 1'b0;
    IOTRANS = 1'b0;
    IOWRITE = 1'b0;
    IOWDATA = '0;
    IOSIZE  = 2'b10;
  endtask

  // Combinational read; consumes no clock edge.
  task automatic rd(input string name, input logic [11:0] a, input logic trans,
                    input logic [31:0] exp);
    IOSEL   = 1'b1;
    IOTRANS = trans;
    IOWRITE = 1'b0;
    IOADDR  = a;
    #1;
    chk(name, IORDATA, exp);
    IOSEL   = 1'b0;
    IOTRANS = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    chk("rst_buzzer", {31'd0, BUZZER}, 32'd0);
    chk("rst_pdone", {31'd0, PERIOD_DONE}, 32'd0);
    rd("rst_cycle", ACycle, 1'b1, 32'h0);
    rd("rst_duty", ADuty, 1'b1, 32'h0);
    tick();
    rd("rst_ctrl", ACtrl, 1'b1, 32'h0);
    rd("rst_status", AStatus, 1'b1, 32'h0);

    // 10-clock period, 3 active clocks
    wr(ACycle, 32'd10, 2'b10);
    wr(ADuty, 32'd3, 2'b10);
    wr(ACtrl, 32'd1, 2'b10);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("p1_buz_%0d", k), {31'd0, BUZZER}, {31'd0, (k % 10) < 3});
      chk($sformatf("p1_pd_%0d", k), {31'd0, PERIOD_DONE},
          {31'd0, ((k % 10) == 0) && (k > 0)});
      tick();
    end
    rd("p1_status_2periods", AStatus, 1'b1, 32'h0002_0001);

    // Mid-period DUTY update takes effect at the next boundary
    tick();
    tick();
    wr(ADuty, 32'd7, 2'b10);
    rd("p2_pend_set", AStatus, 1'b1, 32'h0002_0003);
    for (int k = 23; k < 40; k++) begin
      chk($sformatf("p2_buz_%0d", k), {31'd0, BUZZER},
          {31'd0, (k % 10) < ((k >= 30) ? 7 : 3)});
      if (k == 30) rd("p2_pend_clear", AStatus, 1'b1, 32'h0003_0001);
      tick();
    end

    // DUTY=0, POL=0 then POL=1
    wr(ACtrl, 32'd0, 2'b10);
    chk("p3_disable_inactive", {31'd0, BUZZER}, 32'd0);
    wr(ADuty, 32'd0, 2'b10);
    wr(ACtrl, 32'd1, 2'b10);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p3_d0_%0d", i), {31'd0, BUZZER}, 32'd0);
      tick();
    end
    wr(ACtrl, 32'd3, 2'b10);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p3_d0_pol_%0d", i), {31'd0, BUZZER}, 32'd1);
      tick();
    end

    // DUTY=12 > CYCLE=10
    wr(ACtrl, 32'd0, 2'b10);
    wr(ADuty, 32'd12, 2'b10);
    wr(ACtrl, 32'd1, 2'b10);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p3_d12_%0d", i), {31'd0, BUZZER}, 32'd1);
      tick();
    end
    wr(ACtrl, 32'd3, 2'b10);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p3_d12_pol_%0d", i), {31'd0, BUZZER}, 32'd0);
      tick();
    end

    // CYCLE=0: inactive, no period pulses
    wr(ACtrl, 32'd0, 2'b10);
    wr(ACycle, 32'd0, 2'b10);
    wr(ACtrl, 32'd1, 2'b10);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p3_c0_buz_%0d", i), {31'd0, BUZZER}, 32'd0);
      chk($sformatf("p3_c0_pd_%0d", i), {31'd0, PERIOD_DONE}, 32'd0);
      tick();
    end
    wr(ACtrl, 32'd3, 2'b10);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p3_c0_pol_buz_%0d", i), {31'd0, BUZZER}, 32'd1);
      chk($sformatf("p3_c0_pol_pd_%0d", i), {31'd0, PERIOD_DONE}, 32'd0);
      tick();
    end

    // Nonzero CYCLE written while stalled loads on the very next clock
    wr(ACtrl, 32'd1, 2'b10);
    chk("p3_c0_run_inactive", {31'd0, BUZZER}, 32'd0);
    wr(ACycle, 32'd4, 2'b10);
    chk("p3_c4_write_buz", {31'd0, BUZZER}, 32'd0);
    rd("p3_c4_pend", AStatus, 1'b1, 32'h0000_0003);
    tick();
    chk("p3_c4_loaded_buz", {31'd0, BUZZER}, 32'd1);
    rd("p3_c4_pend_clear", AStatus, 1'b1, 32'h0000_0001);

    // Dropped and ignored writes
    wr(ACtrl, 32'd0, 2'b10);
    wr(ADuty, 32'h0000_00FF, 2'b00);
    rd("p4_byte_write_dropped", ADuty, 1'b1, 32'd12);
    wr(AStatus, 32'hFFFF_FFFF, 2'b10);
    wr(AUnmap, 32'hFFFF_FFFF, 2'b10);
    rd("p4_cycle_kept", ACycle, 1'b1, 32'd4);
    rd("p4_duty_kept", ADuty, 1'b1, 32'd12);
    tick();
    rd("p4_ctrl_kept", ACtrl, 1'b1, 32'd0);
    rd("p4_status_idle", AStatus, 1'b1, 32'd0);
    tick();
    rd("p4_unmapped_read", AUnmap, 1'b1, 32'd0);
    rd("p4_no_trans_read", ACycle, 1'b0, 32'd0);

    // Reset mid-period
    wr(ADuty, 32'd2, 2'b10);
    wr(ACtrl, 32'd1, 2'b10);
    chk("p5_running_buz", {31'd0, BUZZER}, 32'd1);
    tick();
    @(negedge HCLK);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    chk("p5_rst_buz", {31'd0, BUZZER}, 32'd0);
    chk("p5_rst_pd", {31'd0, PERIOD_DONE}, 32'd0);
    rd("p5_rst_cycle", ACycle, 1'b1, 32'd0);
    rd("p5_rst_duty", ADuty, 1'b1, 32'd0);
    tick();
    rd("p5_rst_ctrl", ACtrl, 1'b1, 32'd0);
    rd("p5_rst_status", AStatus, 1'b1, 32'd0);
    wr(ACtrl, 32'd1, 2'b10);
    rd("p5_run_c0", AStatus, 1'b1, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("p5_c0_buz_%0d", i), {31'd0, BUZZER}, 32'd0);
      chk($sformatf("p5_c0_pd_%0d", i), {31'd0, PERIOD_DONE}, 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iop_buzzer_pwm.md
Name: iop_buzzer_pwm

Overview:
- IOP-bus peripheral directly downstream of the AHB-to-IOP bridge. Consumes IOSEL/IOADDR/IOWRITE/IOSIZE/IOTRANS/IOWDATA and returns IORDATA.
- Implements the buzzer register pair (0x10 cycle, 0x14 duty) plus a control register and a status register.
- Generates a PWM buzzer drive with period-boundary shadow reload, so software updates never produce glitched periods.

Parameters:
CNT_WIDTH, 32, width of cycle/duty registers and period counter (1..32); upper IOWDATA bits are ignored, and reads return upper bits as 0.

Ports:
HCLK  in  1  system clock
HRESET  in  1  synchronous reset, active-high
IOSEL  in  1  data-phase select from bridge
IOADDR  in  12  registered transfer address
IOWRITE  in  1  1 = write
IOSIZE  in  2  transfer size; only 2'b10 (word) writes take effect
IOTRANS  in  1  valid transfer (registered HTRANS[1])
IOWDATA  in  32  write data, valid in the data phase
IORDATA  out  32  read data, combinational from IOADDR in the data phase
BUZZER  out  1  registered PWM output
PERIOD_DONE  out  1  one-cycle pulse at each completed period

Behaviour:
- Access qualifier: acc = IOSEL & IOTRANS. A write occurs when acc & IOWRITE & (IOSIZE==2'b10); registers update at the end of that cycle. Non-word writes are silently dropped.
- Register map, decoded on IOADDR[11:2]:
  - 0x10 CYCLE (RW): period in clocks.
  - 0x14 DUTY (RW): active clocks per period.
  - 0x18 CTRL (RW): bit0 EN, bit1 POL (1 = active-low output); other bits read 0.
  - 0x1C STATUS (RO): bit0 RUN, bit1 PEND (a shadow reload is pending), bits[31:16] period count (wraps at 0xFFFF, cleared when EN goes 0->1). Writes to 0x1C are ignored.
  - Unmapped addresses: read 0, writes ignored.
- IORDATA = 0 whenever acc==0 or IOWRITE==1.
- Reset: CYCLE=0, DUTY=0, CTRL=0, shadows=0, cnt=0, period count=0, PEND=0, BUZZER=0, PERIOD_DONE=0.
- State machine:
  - IDLE (EN=0): cnt held at 0; BUZZER=POL (inactive level).
  - EN 0->1 write moves to RUN. At that same edge cyc_sh<=CYCLE, duty_sh<=DUTY, cnt<=0, PEND<=0.
  - RUN -> IDLE on an EN=0 write. Next cycle cnt=0 and BUZZER=POL; no period completion is signalled.
- Writes to CYCLE/DUTY while in RUN set PEND=1. Shadows load only at a period boundary.
- Counter in RUN:
  - If cyc_sh==0: cnt stays 0, BUZZER inactive, no PERIOD_DONE. PEND is serviced on every cycle, so a new nonzero CYCLE takes effect on the next clock.
  - Otherwise cnt increments each clock. When cnt==cyc_sh-1: next cnt=0, PERIOD_DONE=1 for that next cycle, period count +1, and if PEND the shadows reload and PEND clears at the same edge.
- Output: BUZZER <= RUN & (cnt_next < duty_sh), XOR POL. This is a one-cycle registered latency from the counter, so the first active cycle is the cycle after EN is written.
  - duty_sh >= cyc_sh gives a constant active level.
  - duty_sh==0 gives a constant inactive level.
- Simultaneous events:
  - A CYCLE/DUTY write in the same cycle as a boundary: the new value is in the register but is not loaded into the shadow at that edge. PEND=1, and the load happens at the next boundary.
  - An EN=0 write at a boundary: disable wins; PERIOD_DONE is still pulsed for the completed period.
- HRESET mid-operation returns everything to reset values at the next edge. BUZZER is inactive (0) after reset because POL resets to 0.

Test Plan:
- Reset then read 0x10/0x14/0x18/0x1C -> all read 0x00000000; BUZZER=0; PERIOD_DONE=0.
- Write CYCLE=10, DUTY=3, CTRL=1 -> BUZZER high 3 clocks, low 7, repeating. PERIOD_DONE pulses every 10 clocks. STATUS[31:16] reads 2 after 20 clocks.
- While running with CYCLE=10/DUTY=3, write DUTY=7 mid-period -> STATUS.PEND=1. The current period keeps 3 high clocks, the next period has 7, and PEND clears at the boundary.
- Edge duties: DUTY=0 -> BUZZER constant 0. DUTY=12 with CYCLE=10 -> constant 1. CYCLE=0 -> constant 0 and no PERIOD_DONE. POL=1 inverts all three cases.
- Byte write (IOSIZE=00) of 0xFF to 0x14 -> DUTY unchanged. Write to 0x1C or to 0x20 -> no register changes, and 0x20 reads 0.
- Assert HRESET for 1 cycle mid-period -> BUZZER=0, cnt=0, and all registers read 0 on the next access. Write CTRL=1 with CYCLE=0 -> RUN=1, output stays inactive.
